// File: rtl/player_lobby.sv
// Role selection lobby: local buttons claim one free role, remote claims arrive on a ready vector;
// once all roles are covered without overlap for LOCK_DELAY cycles the lobby locks until game_over.
module player_lobby #(
    parameter int N_ROLES    = 2,
    parameter int LOCK_DELAY = 16,
    parameter int LOCAL_PRIO = 0,
    localparam int PID_W     = (N_ROLES > 1) ? $clog2(N_ROLES) : 1
) (
    input  logic               clk60MHz,
    input  logic               rst_n,
    input  logic [N_ROLES-1:0] player_choose,
    input  logic [N_ROLES-1:0] in_player_ready,
    input  logic               game_over,
    output logic [N_ROLES-1:0] player_led,
    output logic [N_ROLES-1:0] out_player_ready,
    output logic [PID_W-1:0]   current_player,
    output logic               locked,
    output logic               conflict
);

    localparam int CNT_W = $clog2(LOCK_DELAY + 1);

    typedef enum logic [1:0] {ST_SELECT, ST_ARMED, ST_LOCKED} state_t;

    state_t             state_q, state_d;
    logic [N_ROLES-1:0] claim_q, claim_d;
    logic [PID_W-1:0]   cp_q, cp_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               locked_q, locked_d;
    logic               conflict_q, conflict_d;

    logic [N_ROLES-1:0] free;
    logic [N_ROLES-1:0] overlap;
    logic [N_ROLES-1:0] low_oh;
    logic [PID_W-1:0]   low_idx;
    logic               all_ok;
    logic               cnt_done;

    assign free     = player_choose & ~in_player_ready;
    assign overlap  = claim_q & in_player_ready;
    assign all_ok   = (claim_q != '0) && ((claim_q | in_player_ready) == '1) && (overlap == '0);
    assign cnt_done = (cnt_q == CNT_W'(LOCK_DELAY));

    // Lowest free role wins; descending scan leaves the lowest index last.
    always_comb begin
        low_oh  = '0;
        low_idx = '0;
        for (int i = N_ROLES - 1; i >= 0; i--) begin
            if (free[i]) begin
                low_oh    = '0;
                low_oh[i] = 1'b1;
                low_idx   = PID_W'(i);
            end
        end
    end

    always_ff @(posedge clk60MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_SELECT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SELECT: if (all_ok) state_d = ST_ARMED;
            ST_ARMED: begin
                if (!all_ok)       state_d = ST_SELECT;
                else if (cnt_done) state_d = ST_LOCKED;
            end
            ST_LOCKED: if (game_over) state_d = ST_SELECT;
            default:   state_d = ST_SELECT;
        endcase
    end

    always_comb begin
        claim_d    = claim_q;
        cp_d       = cp_q;
        cnt_d      = '0;
        conflict_d = 1'b0;
        locked_d   = (state_d == ST_LOCKED);
        case (state_q)
            ST_SELECT: begin
                // A remotely taken role is surrendered before any new press is honoured.
                if ((overlap != '0) && (LOCAL_PRIO == 0)) begin
                    claim_d    = '0;
                    conflict_d = 1'b1;
                end else if (free != '0) begin
                    claim_d = low_oh;
                    cp_d    = low_idx;
                end else if (player_choose != '0) begin
                    conflict_d = 1'b1;
                end
            end
            ST_ARMED: begin
                if (all_ok && !cnt_done) cnt_d = cnt_q + CNT_W'(1);
            end
            ST_LOCKED: begin
                if (game_over) begin
                    claim_d = '0;
                    cp_d    = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk60MHz or negedge rst_n) begin
        if (!rst_n) begin
            claim_q    <= '0;
            cp_q       <= '0;
            cnt_q      <= '0;
            locked_q   <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            claim_q    <= claim_d;
            cp_q       <= cp_d;
            cnt_q      <= cnt_d;
            locked_q   <= locked_d;
            conflict_q <= conflict_d;
        end
    end

    assign player_led       = claim_q;
    assign out_player_ready = claim_q;
    assign current_player   = cp_q;
    assign locked           = locked_q;
    assign conflict         = conflict_q;

endmodule
